// File: rtl/lc3b_mem_responder.sv
// LC-3b memory responder: byte-maskable word store that answers the CPU handshake after a
// programmable latency. Define MEM_RAND_STALL_EN to add 0..3 pseudo-random stall cycles per request.
module lc3b_mem_responder #(
    parameter int ADDR_W        = 8,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_byte_enable,
    input  logic [15:0] mem_address,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_resp,
    output logic        busy,
    output logic        proto_err
);
    localparam int         DEPTH  = 2 ** ADDR_W;
    localparam logic [4:0] RD_LAT = 5'(READ_LATENCY);
    localparam logic [4:0] WR_LAT = 5'(WRITE_LATENCY);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state, state_nxt;
    logic [4:0]        cnt, cnt_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [1:0]        mask_q;
    logic              is_write_q;
    logic [15:0]       store [DEPTH];

    logic              accept, conflict, abort, enter_resp;
    logic [4:0]        stall, lat_total;
    logic              tx_write;
    logic [ADDR_W-1:0] tx_addr;
    logic [15:0]       tx_wdata;
    logic [1:0]        tx_mask;
    logic              unused_addr;

`ifdef MEM_RAND_STALL_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign stall = {3'b000, lfsr[1:0]};
`else
    assign stall = 5'd0;
`endif

    assign accept      = (state == IDLE) && (mem_read ^ mem_write);
    assign conflict    = (state == IDLE) && mem_read && mem_write;
    assign abort       = (state == BUSY) && !(is_write_q ? mem_write : mem_read);
    assign lat_total   = (mem_write ? WR_LAT : RD_LAT) + stall;
    assign unused_addr = ^mem_address;

    // A latency-1 request reaches RESP straight from IDLE, so the live bus must be used there.
    assign tx_write = (state == IDLE) ? mem_write                   : is_write_q;
    assign tx_addr  = (state == IDLE) ? mem_address[ADDR_W:1]       : addr_q;
    assign tx_wdata = (state == IDLE) ? mem_wdata                   : wdata_q;
    assign tx_mask  = (state == IDLE) ? mem_byte_enable             : mask_q;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (lat_total == 5'd1) begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = BUSY;
                        cnt_nxt   = lat_total - 5'd2;
                    end
                end
            end
            BUSY: begin
                if (abort) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 5'd0;
                end else if (cnt == 5'd0) begin
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_nxt = cnt - 5'd1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Store contents survive reset; only control state and the read register are cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 5'd0;
            addr_q     <= '0;
            wdata_q    <= 16'h0000;
            mask_q     <= 2'b00;
            is_write_q <= 1'b0;
            mem_rdata  <= 16'h0000;
            proto_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                addr_q     <= mem_address[ADDR_W:1];
                wdata_q    <= mem_wdata;
                mask_q     <= mem_byte_enable;
                is_write_q <= mem_write;
            end
            if (abort || conflict) begin
                proto_err <= 1'b1;
            end
            if (enter_resp && !tx_write) begin
                mem_rdata <= store[tx_addr];
            end
            if (enter_resp && tx_write) begin
                if (tx_mask[0]) store[tx_addr][7:0]  <= tx_wdata[7:0];
                if (tx_mask[1]) store[tx_addr][15:8] <= tx_wdata[15:8];
            end
        end
    end

    assign mem_resp = (state == RESP);
    assign busy     = (state != IDLE);

endmodule
